requantize_pipe: RTL and testbench
==================================

// Module: requantize_pipe
// PURPOSE
//   Multi-lane requantizer: converts SIZE signed IN_W-bit accumulator lanes to
//   signed OUT_W-bit activations. Each lane is arithmetic right-shifted by a
//   runtime shift with round-half-up, then saturated to the OUT_W range.
//   2-stage valid/ready pipeline between a conv/fc accumulator and the next layer.
// PARAMETERS
//   IN_W    32  signed accumulator width per lane
//   OUT_W   8   signed output width per lane (OUT_W < IN_W)
//   SIZE    4   number of parallel lanes
//   SHIFT_W 5   width of the shift amount; legal shift 0..IN_W-1
// PORTS
//   clock      in   1            rising-edge clock
//   reset      in   1            synchronous, active-low reset
//   cfg_wr     in   1            load cfg_shift into the shift register
//   cfg_shift  in   SHIFT_W      new right-shift amount
//   in_valid   in   1            pixel_in valid
//   in_ready   out  1            block accepts a beat this cycle
//   pixel_in   in   IN_W*SIZE    lane i = pixel_in[IN_W*i +: IN_W], signed
//   out_valid  out  1            pixel_out valid
//   out_ready  in   1            downstream accepts this cycle
//   pixel_out  out  OUT_W*SIZE   lane i = pixel_out[OUT_W*i +: OUT_W], signed
//   out_sat    out  SIZE         per-lane flag: lane was clipped
//   sat_count  out  32           only with REQUANT_SAT_COUNT_EN (see CONFIGURATION)
// BEHAVIOUR
//   - Reset (reset==0 at a clock edge): out_valid=0, stage-1 valid=0,
//     pixel_out=0, out_sat=0, shift register=0. Beats in flight are discarded.
//     in_ready=0 in every cycle where reset==0.
//   - Shift register: loaded on cfg_wr. An accepted beat uses the register value
//     at its acceptance edge; a cfg_wr in the same cycle affects only later beats.
//     The shift travels with the beat, so in-flight beats keep the old shift.
//   - Handshake: transfer in when in_valid&in_ready; out when out_valid&out_ready.
//     Both stages advance when the output register is empty or being drained:
//       adv = !out_valid | out_ready
//       in_ready = reset & (!s1_valid | adv)
//     in_ready depends combinationally on out_ready.
//     pixel_out, out_sat and out_valid hold stable while out_valid & !out_ready.
//   - Latency: an accepted beat appears on out_valid 2 edges after acceptance
//     when there is no stall. Throughput is 1 beat/cycle. Up to 2 beats are
//     buffered: stage-1 plus the output register.
//   - Stage 1 (per lane), computed at acceptance in IN_W+1 bits:
//       r = (s==0) ? x : (x + (1<<(s-1))) >>> s   // arithmetic shift
//     Rounding is half toward +inf, e.g. -1.5 -> -1. IN_W+1 bits prevent
//     overflow of the rounding add at the positive maximum.
//   - Stage 2 (output register):
//       r >  2^(OUT_W-1)-1  -> 2^(OUT_W-1)-1, sat=1
//       r < -2^(OUT_W-1)    -> -2^(OUT_W-1),  sat=1
//       otherwise           -> r[OUT_W-1:0],  sat=0
//   - Simultaneous in/out handshake with both stages full: allowed; occupancy is
//     unchanged and order is preserved.
//   - cfg_shift >= IN_W is illegal; the result is undefined and the bench must
//     not drive it.
// CONFIGURATION
//   REQUANT_SAT_COUNT_EN defined:
//     - sat_count port exists and resets to 0.
//     - On each output handshake it adds popcount(out_sat), saturating at
//       32'hFFFFFFFF.
//     - It is cleared by cfg_wr. If cfg_wr and an output handshake coincide,
//       the clear wins.
//   REQUANT_SAT_COUNT_EN undefined: no sat_count port and no counter logic.
//     All other behaviour is identical.
// TESTING  (IN_W=32, OUT_W=8, SIZE=4)
//   1. Shift=4, lanes {384, 5000, -5000, 23}, out_ready=1
//      -> 2 cycles later pixel_out {24, 127, -128, 1}, out_sat=4'b0110.
//   2. Rounding, shift=4, lanes {24, -24, 8, -8}
//      -> {2, -1, 1, 0}. Shift=0, lanes {100, -100, 127, 128}
//      -> {100, -100, 127, 127}, out_sat=4'b1000.
//   3. out_ready=0, three back-to-back beats offered
//      -> in_ready drops after 2 accepted. Raise out_ready: beats exit in order,
//      one per cycle, and pixel_out is stable while stalled.
//   4. Beat accepted with shift=4 and cfg_wr shift=0 in the same cycle, second
//      beat next cycle, both lanes0=384 -> outputs 24 then 127 (sat).
//   5. Reset low for 1 cycle with 2 beats in flight -> out_valid=0 and
//      in_ready=0 that cycle. No stale beat appears after reset is released.
//   6. (REQUANT_SAT_COUNT_EN) Test 1 beat repeated 3 times -> sat_count=6;
//      cfg_wr -> 0. Preload the count near the maximum -> it holds at FFFFFFFF.

Source files
------------

// File: rtl/requantize_pipe.sv
// Multi-lane requantizer: per-lane rounding right shift, then saturation to OUT_W, 2-stage pipe.
// Optional saturation event counter enabled by defining REQUANT_SAT_COUNT_EN.
module requantize_pipe #(
    parameter int unsigned IN_W    = 32,
    parameter int unsigned OUT_W   = 8,
    parameter int unsigned SIZE    = 4,
    parameter int unsigned SHIFT_W = 5
) (
    input  logic                  clock_i,
    input  logic                  reset_ni,
    input  logic                  cfg_wr_i,
    input  logic [SHIFT_W-1:0]    cfg_shift_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [IN_W*SIZE-1:0]  pixel_in_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [OUT_W*SIZE-1:0] pixel_out_o,
    output logic [SIZE-1:0]       out_sat_o
`ifdef REQUANT_SAT_COUNT_EN
    ,
    output logic [31:0]           sat_count_o
`endif
);

    localparam logic signed [IN_W:0] SatMax = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W:0] SatMin = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic signed [IN_W:0] RndOne = {{IN_W{1'b0}}, 1'b1};

    logic [SHIFT_W-1:0]    shift_q, shift_d;
    logic                  s1_valid_q, s1_valid_d;
    logic signed [IN_W:0]  s1_q [SIZE];
    logic signed [IN_W:0]  s1_d [SIZE];
    logic signed [IN_W:0]  rnd [SIZE];
    logic signed [IN_W:0]  ext;
    logic                  out_valid_q, out_valid_d;
    logic [OUT_W*SIZE-1:0] pix_q, pix_d;
    logic [SIZE-1:0]       sat_q, sat_d;
    logic                  adv, accept;

    assign adv         = !out_valid_q || out_ready_i;
    assign in_ready_o  = reset_ni && (!s1_valid_q || adv);
    assign accept      = in_valid_i && in_ready_o;
    assign out_valid_o = out_valid_q;
    assign pixel_out_o = pix_q;
    assign out_sat_o   = sat_q;

    // Rounding add is done one bit wider so the positive maximum cannot wrap.
    always_comb begin
        ext = '0;
        for (int i = 0; i < SIZE; i++) begin
            ext = {pixel_in_i[IN_W*i+IN_W-1], pixel_in_i[IN_W*i +: IN_W]};
            if (shift_q == '0) begin
                rnd[i] = ext;
            end else begin
                rnd[i] = (ext + (RndOne << (shift_q - SHIFT_W'(1)))) >>> shift_q;
            end
        end
    end

    always_comb begin
        shift_d     = shift_q;
        s1_valid_d  = s1_valid_q;
        s1_d        = s1_q;
        out_valid_d = out_valid_q;
        pix_d       = pix_q;
        sat_d       = sat_q;
        if (cfg_wr_i) begin
            shift_d = cfg_shift_i;
        end
        if (in_ready_o) begin
            s1_valid_d = in_valid_i;
        end
        if (accept) begin
            s1_d = rnd;
        end
        if (adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                for (int i = 0; i < SIZE; i++) begin
                    if (s1_q[i] > SatMax) begin
                        pix_d[OUT_W*i +: OUT_W] = SatMax[OUT_W-1:0];
                        sat_d[i]                = 1'b1;
                    end else if (s1_q[i] < SatMin) begin
                        pix_d[OUT_W*i +: OUT_W] = SatMin[OUT_W-1:0];
                        sat_d[i]                = 1'b1;
                    end else begin
                        pix_d[OUT_W*i +: OUT_W] = s1_q[i][OUT_W-1:0];
                        sat_d[i]                = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            shift_q     <= '0;
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            pix_q       <= '0;
            sat_q       <= '0;
            for (int i = 0; i < SIZE; i++) begin
                s1_q[i] <= '0;
            end
        end else begin
            shift_q     <= shift_d;
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            pix_q       <= pix_d;
            sat_q       <= sat_d;
            s1_q        <= s1_d;
        end
    end

`ifdef REQUANT_SAT_COUNT_EN
    logic [31:0] sat_count_q, sat_count_d, sat_inc;
    logic [32:0] sat_sum;

    assign sat_count_o = sat_count_q;

    // A cfg_wr clear takes priority over a coincident output handshake.
    always_comb begin
        sat_inc = '0;
        for (int i = 0; i < SIZE; i++) begin
            sat_inc = sat_inc + 32'(sat_q[i]);
        end
        sat_sum     = {1'b0, sat_count_q} + {1'b0, sat_inc};
        sat_count_d = sat_count_q;
        if (cfg_wr_i) begin
            sat_count_d = '0;
        end else if (out_valid_q && out_ready_i) begin
            sat_count_d = sat_sum[32] ? 32'hFFFF_FFFF : sat_sum[31:0];
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            sat_count_q <= '0;
        end else begin
            sat_count_q <= sat_count_d;
        end
    end
`endif

endmodule

// File: tb/tb_requantize_pipe.sv
// Directed self-checking bench for requantize_pipe (IN_W=32, OUT_W=8, SIZE=4).
module tb_requantize_pipe;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         cfg_wr;
    logic [4:0]   cfg_shift;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] pixel_in;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  pixel_out;
    logic [3:0]   out_sat;
`ifdef REQUANT_SAT_COUNT_EN
    logic [31:0]  sat_count;
`endif

    int total = 0;
    int bad   = 0;

    requantize_pipe #(
        .IN_W   (32),
        .OUT_W  (8),
        .SIZE   (4),
        .SHIFT_W(5)
    ) dut (
        .clock_i    (clock),
        .reset_ni   (reset_n),
        .cfg_wr_i   (cfg_wr),
        .cfg_shift_i(cfg_shift),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .pixel_in_i (pixel_in),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .pixel_out_o(pixel_out),
        .out_sat_o  (out_sat)
`ifdef REQUANT_SAT_COUNT_EN
        ,
        .sat_count_o(sat_count)
`endif
    );

    always #5 clock = ~clock;

    function automatic logic [127:0] pk(input int a, input int b, input int c, input int d);
        return {d[31:0], c[31:0], b[31:0], a[31:0]};
    endfunction

    function automatic logic [31:0] pk8(input int a, input int b, input int c, input int d);
        return {d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_shift(input logic [4:0] s);
        cfg_wr    = 1'b1;
        cfg_shift = s;
        tick();
        cfg_wr    = 1'b0;
    endtask

    // Offer one beat to an idle pipe; returns with its result on the output.
    task automatic run_beat(input logic [127:0] px);
        pixel_in  = px;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        cfg_wr    = 1'b0;
        cfg_shift = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        pixel_in  = '0;
        tick();
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid);
        end
        total++;
        if (in_ready !== 1'b0) begin
            bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready);
        end
        total++;
        if (pixel_out !== 32'h0 || out_sat !== 4'h0) begin
            bad++; $display("FAIL reset_data got=%h/%b want=0/0", pixel_out, out_sat);
        end
        reset_n = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL release_in_ready got=%b want=1", in_ready);
        end
        // Shift register resets to 0, so this beat passes unshifted.
        run_beat(pk(100, -100, 127, 128));
        total++;
        if (out_valid !== 1'b1 || pixel_out !== pk8(100, -100, 127, 127) || out_sat !== 4'b1000)
        begin
            bad++;
            $display("FAIL shift0 got=%b/%h/%b want=1/%h/1000", out_valid, pixel_out, out_sat,
                     pk8(100, -100, 127, 127));
        end
        tick();
    endtask

    task automatic test_basic();
        set_shift(5'd4);
        pixel_in  = pk(384, 5000, -5000, 23);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL basic_in_ready got=%b want=1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL basic_latency got=%b want=0", out_valid);
        end
        tick();
        total++;
        if (out_valid !== 1'b1 || pixel_out !== pk8(24, 127, -128, 1) || out_sat !== 4'b0110)
        begin
            bad++;
            $display("FAIL basic got=%b/%h/%b want=1/%h/0110", out_valid, pixel_out, out_sat,
                     pk8(24, 127, -128, 1));
        end
        tick();
    endtask

    task automatic test_rounding();
        run_beat(pk(24, -24, 8, -8));
        total++;
        if (pixel_out !== pk8(2, -1, 1, 0) || out_sat !== 4'b0000) begin
            bad++;
            $display("FAIL round got=%h/%b want=%h/0000", pixel_out, out_sat, pk8(2, -1, 1, 0));
        end
        tick();
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        pixel_in  = pk(16, 0, 0, 0);
        tick();
        pixel_in  = pk(32, 0, 0, 0);
        tick();
        pixel_in  = pk(48, 0, 0, 0);
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++; $display("FAIL stall_in_ready got=%b want=0", in_ready);
        end
        tick();
        total++;
        if (out_valid !== 1'b1 || pixel_out !== pk8(1, 0, 0, 0) || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL stall_hold got=%b/%h/%b want=1/%h/0", out_valid, pixel_out, in_ready,
                     pk8(1, 0, 0, 0));
        end
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL stall_release_ready got=%b want=1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || pixel_out !== pk8(2, 0, 0, 0)) begin
            bad++; $display("FAIL stall_second got=%b/%h want=1/%h", out_valid, pixel_out,
                            pk8(2, 0, 0, 0));
        end
        tick();
        total++;
        if (out_valid !== 1'b1 || pixel_out !== pk8(3, 0, 0, 0)) begin
            bad++; $display("FAIL stall_third got=%b/%h want=1/%h", out_valid, pixel_out,
                            pk8(3, 0, 0, 0));
        end
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL stall_drained got=%b want=0", out_valid);
        end
    endtask

    task automatic test_cfg_race();
        out_ready = 1'b1;
        cfg_wr    = 1'b1;
        cfg_shift = 5'd0;
        pixel_in  = pk(384, 0, 0, 0);
        in_valid  = 1'b1;
        tick();
        cfg_wr    = 1'b0;
        tick();
        in_valid  = 1'b0;
        total++;
        if (out_valid !== 1'b1 || pixel_out !== pk8(24, 0, 0, 0) || out_sat !== 4'b0000) begin
            bad++; $display("FAIL race_old_shift got=%b/%h/%b want=1/%h/0000", out_valid,
                            pixel_out, out_sat, pk8(24, 0, 0, 0));
        end
        tick();
        total++;
        if (out_valid !== 1'b1 || pixel_out !== pk8(127, 0, 0, 0) || out_sat !== 4'b0001) begin
            bad++; $display("FAIL race_new_shift got=%b/%h/%b want=1/%h/0001", out_valid,
                            pixel_out, out_sat, pk8(127, 0, 0, 0));
        end
        tick();
    endtask

    task automatic test_reset_flight();
        int seen = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        pixel_in  = pk(5, 0, 0, 0);
        tick();
        pixel_in  = pk(6, 0, 0, 0);
        tick();
        in_valid  = 1'b0;
        reset_n   = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++; $display("FAIL flight_in_ready_comb got=%b want=0", in_ready);
        end
        tick();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            bad++; $display("FAIL flight_reset got=%b/%b want=0/0", out_valid, in_ready);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (out_valid === 1'b1) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++; $display("FAIL flight_stale got=%0d want=0", seen);
        end
    endtask

`ifdef REQUANT_SAT_COUNT_EN
    task automatic test_sat_count();
        set_shift(5'd4);
        for (int i = 0; i < 3; i++) begin
            run_beat(pk(384, 5000, -5000, 23));
        end
        tick();
        total++;
        if (sat_count !== 32'd6) begin
            bad++; $display("FAIL satcnt_sum got=%0d want=6", sat_count);
        end
        set_shift(5'd4);
        total++;
        if (sat_count !== 32'd0) begin
            bad++; $display("FAIL satcnt_clear got=%0d want=0", sat_count);
        end
        dut.sat_count_q = 32'hFFFF_FFFE;
        run_beat(pk(384, 5000, -5000, 23));
        tick();
        total++;
        if (sat_count !== 32'hFFFF_FFFF) begin
            bad++; $display("FAIL satcnt_clip got=%h want=ffffffff", sat_count);
        end
        run_beat(pk(384, 5000, -5000, 23));
        tick();
        total++;
        if (sat_count !== 32'hFFFF_FFFF) begin
            bad++; $display("FAIL satcnt_hold got=%h want=ffffffff", sat_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_stall();
        test_cfg_race();
        test_reset_flight();
`ifdef REQUANT_SAT_COUNT_EN
        test_sat_count();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
